// File: rtl/decade_timer_ctrl_if.sv
// Control strobes and status outputs of the decade countdown timer.
// The controlling side uses master; the timer uses slave.
interface decade_timer_ctrl_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  start;
    logic                  stop;
    logic                  periodic;
    logic [4*DIGITS-1:0]   count;
    logic                  busy;
    logic                  running;
    logic                  done;
    logic                  err;

    modport master (
        output load, load_value, start, stop, periodic,
        input  count, busy, running, done, err
    );

    modport slave (
        input  load, load_value, start, stop, periodic,
        output count, busy, running, done, err
    );
endinterface

// File: rtl/decade_timer_ctrl.sv
// Programmable countdown timer driving a cascaded BCD down-counter, with
// prescaler, pause/resume and one-shot or periodic reload.
module decade_timer_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               clear,
    decade_timer_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t          state;
    logic [W-1:0]    count_q;
    logic [W-1:0]    reload_q;
    logic [PW-1:0]   psc;
    logic            busy_q, running_q, done_q, err_q;

    logic [W-1:0]    dec;
    logic            borrow;
    logic            ld_valid;
    logic            ld_ok;
    logic            eff_zero;
    logic            step;
    logic            terminal;

    // Borrow ripples only through zero digits; the first nonzero digit absorbs it.
    always_comb begin
        dec    = count_q;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec[4*i +: 4] = 4'd9;
                end else begin
                    dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        ld_valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.load_value[4*i +: 4] > 4'd9) ld_valid = 1'b0;
        end
        ld_ok    = bus.load && ld_valid && (state != RUN);
        eff_zero = ld_ok ? (bus.load_value == '0) : (count_q == '0);
        step     = (state == RUN) && (psc == PW'(PRESCALE - 1));
        terminal = step && (count_q == W'(1));
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            psc       <= '0;
            busy_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load && state != RUN) begin
                if (ld_valid) begin
                    count_q  <= bus.load_value;
                    reload_q <= bus.load_value;
                    err_q    <= 1'b0;
                end else begin
                    err_q    <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (!bus.stop && bus.start && !eff_zero) begin
                        state     <= RUN;
                        psc       <= '0;
                        busy_q    <= 1'b1;
                        running_q <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.start && !eff_zero) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    // A stop in the same cycle as a step wins and freezes the step.
                    if (bus.stop) begin
                        state     <= PAUSED;
                        running_q <= 1'b0;
                    end else if (step) begin
                        psc <= '0;
                        if (terminal) begin
                            done_q <= 1'b1;
                            if (bus.periodic) begin
                                count_q <= reload_q;
                            end else begin
                                count_q   <= '0;
                                state     <= IDLE;
                                busy_q    <= 1'b0;
                                running_q <= 1'b0;
                            end
                        end else begin
                            count_q <= dec;
                        end
                    end else begin
                        psc <= psc + PW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_decade_timer_ctrl.sv
// Directed bench for decade_timer_ctrl: one instance with PRESCALE=1 and one
// with PRESCALE=3, both two digits wide.
module tb_decade_timer_ctrl;
    logic clk;
    logic clear_a, clear_b;
    int   vectors     = 0;
    int   miscompares = 0;

    decade_timer_ctrl_if #(.DIGITS(2)) a_if ();
    decade_timer_ctrl_if #(.DIGITS(2)) b_if ();

    decade_timer_ctrl #(.DIGITS(2), .PRESCALE(1)) dut_a (
        .clk(clk), .clear(clear_a), .bus(a_if)
    );
    decade_timer_ctrl #(.DIGITS(2), .PRESCALE(3)) dut_b (
        .clk(clk), .clear(clear_b), .bus(b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    initial begin
        clear_a = 1'b0; clear_b = 1'b0;
        a_if.load = 0; a_if.load_value = '0; a_if.start = 0; a_if.stop = 0; a_if.periodic = 0;
        b_if.load = 0; b_if.load_value = '0; b_if.start = 0; b_if.stop = 0; b_if.periodic = 0;
        #12;
        chk("rst_count", a_if.count, 0);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_running", a_if.running, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_err", a_if.err, 0);
        @(negedge clk);
        clear_a = 1'b1; clear_b = 1'b1;

        // One-shot countdown from 12
        a_if.load = 1; a_if.load_value = 8'h12; cyc(); a_if.load = 0;
        chk("ld12_count", a_if.count, 8'h12);
        chk("ld12_busy", a_if.busy, 0);
        a_if.start = 1; cyc(); a_if.start = 0;
        chk("st12_running", a_if.running, 1);
        chk("st12_count", a_if.count, 8'h12);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("dn_count", a_if.count, bcd(12 - i));
            chk("dn_done", a_if.done, (i == 12) ? 1 : 0);
            chk("dn_busy", a_if.busy, (i == 12) ? 0 : 1);
        end
        cyc();
        chk("dn_done_after", a_if.done, 0);
        chk("dn_count_after", a_if.count, 8'h00);

        // Borrow 20 -> 19, then effective-count rule on load+start
        a_if.load = 1; a_if.load_value = 8'h20; cyc(); a_if.load = 0;
        a_if.start = 1; cyc(); a_if.start = 0;
        chk("br_count0", a_if.count, 8'h20);
        cyc();
        chk("br_count1", a_if.count, 8'h19);
        a_if.stop = 1; cyc();
        chk("br_pause_count", a_if.count, 8'h19);
        chk("br_pause_busy", a_if.busy, 1);
        cyc(); a_if.stop = 0;
        chk("br_idle_busy", a_if.busy, 0);
        chk("br_idle_count", a_if.count, 8'h19);
        a_if.load = 1; a_if.load_value = 8'h00; a_if.start = 1; cyc();
        chk("ld0st_busy", a_if.busy, 0);
        chk("ld0st_count", a_if.count, 8'h00);
        a_if.load_value = 8'h05; cyc(); a_if.load = 0; a_if.start = 0;
        chk("ld5st_running", a_if.running, 1);
        chk("ld5st_count", a_if.count, 8'h05);
        a_if.stop = 1; cyc(); cyc(); a_if.stop = 0;
        chk("ld5_idle_busy", a_if.busy, 0);

        // Pause / resume
        a_if.load = 1; a_if.load_value = 8'h50; cyc(); a_if.load = 0;
        a_if.start = 1; cyc(); a_if.start = 0;
        chk("pr_count0", a_if.count, 8'h50);
        repeat (5) cyc();
        chk("pr_count5", a_if.count, 8'h45);
        a_if.stop = 1; cyc(); a_if.stop = 0;
        chk("pr_pause_count", a_if.count, 8'h45);
        chk("pr_pause_running", a_if.running, 0);
        chk("pr_pause_busy", a_if.busy, 1);
        cyc();
        chk("pr_frozen", a_if.count, 8'h45);
        a_if.load = 1; a_if.load_value = 8'h30; cyc(); a_if.load = 0;
        chk("pr_ld30", a_if.count, 8'h30);
        chk("pr_ld30_running", a_if.running, 0);
        a_if.start = 1; cyc(); a_if.start = 0;
        chk("pr_resume_running", a_if.running, 1);
        chk("pr_resume_count", a_if.count, 8'h30);
        cyc();
        chk("pr_step29", a_if.count, 8'h29);
        a_if.start = 1; a_if.stop = 1; cyc(); a_if.start = 0; a_if.stop = 0;
        chk("pr_both_running", a_if.running, 0);
        chk("pr_both_busy", a_if.busy, 1);
        chk("pr_both_count", a_if.count, 8'h29);
        a_if.stop = 1; cyc(); a_if.stop = 0;
        chk("pr_idle_busy", a_if.busy, 0);
        chk("pr_idle_count", a_if.count, 8'h29);

        // Invalid BCD loads
        a_if.load = 1; a_if.load_value = 8'h1A; cyc(); a_if.load = 0;
        chk("inv_err", a_if.err, 1);
        chk("inv_count", a_if.count, 8'h29);
        a_if.start = 1; cyc(); a_if.start = 0;
        chk("inv_run", a_if.running, 1);
        a_if.load = 1; a_if.load_value = 8'h0A; cyc(); a_if.load = 0;
        chk("inv_run_err", a_if.err, 1);
        chk("inv_run_count", a_if.count, 8'h28);
        a_if.stop = 1; cyc(); cyc(); a_if.stop = 0;
        chk("inv_idle_busy", a_if.busy, 0);
        a_if.load = 1; a_if.load_value = 8'h07; cyc(); a_if.load = 0;
        chk("val_err", a_if.err, 0);
        chk("val_count", a_if.count, 8'h07);

        // Asynchronous reset mid-run
        a_if.load = 1; a_if.load_value = 8'h99; cyc(); a_if.load = 0;
        a_if.start = 1; cyc(); a_if.start = 0;
        repeat (10) cyc();
        chk("ar_pre_count", a_if.count, 8'h89);
        #2 clear_a = 1'b0;
        #1;
        chk("ar_count", a_if.count, 0);
        chk("ar_busy", a_if.busy, 0);
        chk("ar_done", a_if.done, 0);
        chk("ar_running", a_if.running, 0);
        cyc(); cyc();
        clear_a = 1'b1;
        cyc(); cyc();
        chk("ar_after_count", a_if.count, 0);
        chk("ar_after_busy", a_if.busy, 0);
        chk("ar_after_done", a_if.done, 0);

        // Periodic reload with PRESCALE=3
        b_if.load = 1; b_if.load_value = 8'h03; b_if.periodic = 1; cyc(); b_if.load = 0;
        b_if.start = 1; cyc(); b_if.start = 0;
        chk("per_count0", b_if.count, 8'h03);
        chk("per_running0", b_if.running, 1);
        for (int k = 1; k <= 18; k++) begin
            cyc();
            chk("per_count", b_if.count, 8'(3 - ((k / 3) % 3)));
            chk("per_done", b_if.done, (k % 9 == 0) ? 1 : 0);
        end
        b_if.periodic = 0;
        for (int k = 19; k <= 27; k++) begin
            cyc();
            if (k == 27) begin
                chk("os_count", b_if.count, 8'h00);
                chk("os_done", b_if.done, 1);
                chk("os_busy", b_if.busy, 0);
            end else begin
                chk("os_run_count", b_if.count, 8'(3 - ((k / 3) % 3)));
                chk("os_run_done", b_if.done, 0);
            end
        end
        cyc();
        chk("os_done_after", b_if.done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
